// File: rtl/serial_addsub_unit.sv
// Bit-serial add/subtract engine: one full-adder slice plus a carry flop,
// LSB first, with a start/busy/done handshake.
module serial_addsub_unit #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_mode,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_carry
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic {S_IDLE, S_RUN} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             c_q, c_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             s_bit;
   logic             maj;

   // Next-state and datapath for the serial slice
   always_comb begin
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      res_d   = res_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      sum_d   = sum_q;
      carry_d = carry_q;
      s_bit   = sa_q[0] ^ sb_q[0] ^ c_q;
      maj     = (sa_q[0] & sb_q[0]) | (sa_q[0] & c_q) | (sb_q[0] & c_q);

      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               // Subtract is A + ~B + 1: invert B and seed the carry with mode
               sa_d    = i_a;
               sb_d    = i_b ^ {WIDTH{i_mode}};
               c_d     = i_mode;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            c_d             = maj;
            res_d           = res_q >> 1;
            res_d[WIDTH-1]  = s_bit;
            sa_d            = sa_q >> 1;
            sb_d            = sb_q >> 1;
            cnt_d           = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               sum_d   = res_d;
               carry_d = maj;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d == S_RUN);
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= S_IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         res_q   <= '0;
         c_q     <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sum_q   <= '0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         res_q   <= res_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
      end
   end

   assign o_busy  = busy_q;
   assign o_done  = done_q;
   assign o_sum   = sum_q;
   assign o_carry = carry_q;

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Self-checking bench for serial_addsub_unit against an arithmetic reference.
module tb_serial_addsub_unit;

   localparam int unsigned W = 4;

   logic         clk;
   logic         rst_n;
   logic         i_start;
   logic [W-1:0] i_a;
   logic [W-1:0] i_b;
   logic         i_mode;
   logic         o_busy;
   logic         o_done;
   logic [W-1:0] o_sum;
   logic         o_carry;

   int n_vec = 0;
   int n_err = 0;

   serial_addsub_unit #(.WIDTH(W)) dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .i_start   (i_start),
      .i_a       (i_a),
      .i_b       (i_b),
      .i_mode    (i_mode),
      .o_busy    (o_busy),
      .o_done    (o_done),
      .o_sum     (o_sum),
      .o_carry   (o_carry)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: {carry, sum}; subtract carry means "no borrow", i.e. A >= B
   function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic m);
      int unsigned t;
      if (m) t = 32'(a) + (32'd1 << W) - 32'(b);
      else   t = 32'(a) + 32'(b);
      return (W+1)'(t);
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Issues one start pulse, scrambles operands after acceptance, waits for done
   task automatic do_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                         output int lat, output int busy_cnt, output logic [W:0] res,
                         output logic busy_at_done, output logic done_again);
      i_a = a; i_b = b; i_mode = m; i_start = 1'b1;
      step();
      i_start = 1'b0;
      i_a = W'($urandom); i_b = W'($urandom); i_mode = 1'($urandom);
      lat = -1;
      busy_cnt = 0;
      for (int c = 0; c <= int'(W) + 4; c++) begin
         if (o_done) begin
            lat = c;
            break;
         end
         if (o_busy) busy_cnt++;
         step();
      end
      res = {o_carry, o_sum};
      busy_at_done = o_busy;
      step();
      done_again = o_done;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; i_start = 1'b1; i_a = 4'd5; i_b = 4'd3; i_mode = 1'b0;
      repeat (3) step();
      n_vec++;
      if ({o_busy, o_done, o_carry, o_sum} !== '0) begin
         n_err++;
         $display("FAIL reset_hold: got %0h expected 0", {o_busy, o_done, o_carry, o_sum});
      end
      i_start = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_vec++;
         if ({o_busy, o_done, o_carry, o_sum} !== '0) begin
            n_err++;
            $display("FAIL reset_idle[%0d]: got %0h expected 0", i,
                     {o_busy, o_done, o_carry, o_sum});
         end
      end
   endtask

   task automatic test_add;
      int lat, bc;
      logic [W:0] r;
      logic bd, da;
      do_txn(4'd3, 4'd2, 1'b0, lat, bc, r, bd, da);
      n_vec += 5;
      if (lat != int'(W)) begin n_err++; $display("FAIL add_latency: got %0d expected %0d", lat, W); end
      if (bc != int'(W)) begin n_err++; $display("FAIL add_busy_cycles: got %0d expected %0d", bc, W); end
      if (r !== 5'b0_0101) begin n_err++; $display("FAIL add_result: got %0d expected 5", r); end
      if (bd !== 1'b0) begin n_err++; $display("FAIL add_busy_at_done: got %0b expected 0", bd); end
      if (da !== 1'b0) begin n_err++; $display("FAIL add_done_width: got %0b expected 0", da); end
   endtask

   task automatic test_sub_wrap;
      logic [W-1:0] av[4] = '{4'd7, 4'd2, 4'd15, 4'd0};
      logic [W-1:0] bv[4] = '{4'd4, 4'd3, 4'd1,  4'd0};
      logic         mv[4] = '{1'b1, 1'b1, 1'b0,  1'b1};
      int lat, bc;
      logic [W:0] r, e;
      logic bd, da;
      for (int i = 0; i < 4; i++) begin
         do_txn(av[i], bv[i], mv[i], lat, bc, r, bd, da);
         e = model(av[i], bv[i], mv[i]);
         n_vec += 2;
         if (r !== e) begin
            n_err++;
            $display("FAIL subwrap_result[%0d]: a=%0d b=%0d m=%0b got c=%0b s=%0d expected c=%0b s=%0d",
                     i, av[i], bv[i], mv[i], r[W], r[W-1:0], e[W], e[W-1:0]);
         end
         if (lat != int'(W)) begin n_err++; $display("FAIL subwrap_latency[%0d]: got %0d expected %0d", i, lat, W); end
      end
   endtask

   task automatic test_protocol;
      int cyc, k;
      i_a = 4'd9; i_b = 4'd6; i_mode = 1'b0; i_start = 1'b1;
      step();
      i_start = 1'b0;
      cyc = 0;
      while (!o_done && cyc < int'(W) + 6) begin
         if (cyc == 1) i_a = W'($urandom);
         if (cyc == 2) begin i_start = 1'b1; i_a = 4'd1; i_b = 4'd1; i_mode = 1'b0; end
         if (cyc == 3) begin i_a = 4'd5; i_b = 4'd5; i_mode = 1'b1; end
         step();
         cyc++;
      end
      n_vec += 3;
      if (cyc != int'(W)) begin n_err++; $display("FAIL proto_first_latency: got %0d expected %0d", cyc, W); end
      if ({o_carry, o_sum} !== 5'b0_1111) begin n_err++; $display("FAIL proto_first_result: got %0d expected 15", {o_carry, o_sum}); end
      if (o_busy !== 1'b0) begin n_err++; $display("FAIL proto_busy_at_done: got %0b expected 0", o_busy); end
      step();
      i_start = 1'b0;
      i_a = W'($urandom);
      n_vec += 3;
      if (o_done !== 1'b0) begin n_err++; $display("FAIL proto_done_repeat: got %0b expected 0", o_done); end
      if (o_busy !== 1'b1) begin n_err++; $display("FAIL proto_b2b_accept: got %0b expected 1", o_busy); end
      if (o_sum !== 4'd15) begin n_err++; $display("FAIL proto_sum_hold: got %0d expected 15", o_sum); end
      k = 1;
      while (!o_done && k < int'(W) + 8) begin
         step();
         k++;
      end
      n_vec += 2;
      if (k != int'(W) + 1) begin n_err++; $display("FAIL proto_second_spacing: got %0d expected %0d", k, W + 1); end
      if ({o_carry, o_sum} !== 5'b1_0000) begin n_err++; $display("FAIL proto_second_result: got %0d expected 16", {o_carry, o_sum}); end
      step();
   endtask

   task automatic test_back_to_back;
      logic [W:0] q[$];
      logic [W:0] e;
      logic [W-1:0] a, b;
      logic m, prev_done;
      int cyc, last_done, ndone;
      a = W'($urandom); b = W'($urandom); m = 1'($urandom);
      q.push_back(model(a, b, m));
      i_a = a; i_b = b; i_mode = m; i_start = 1'b1;
      step();
      cyc = 0; last_done = -1; ndone = 0; prev_done = 1'b0;
      while (ndone < 6 && cyc < 100) begin
         if (o_done) begin
            e = (q.size() > 0) ? q.pop_front() : 'x;
            n_vec += 3;
            if ({o_carry, o_sum} !== e) begin
               n_err++;
               $display("FAIL b2b_result[%0d]: got %0d expected %0d", ndone, {o_carry, o_sum}, e);
            end
            if (cyc - last_done != ((last_done < 0) ? int'(W) + 1 : int'(W) + 1)) begin
               n_err++;
               $display("FAIL b2b_spacing[%0d]: got %0d expected %0d", ndone, cyc - last_done, W + 1);
            end
            if (prev_done !== 1'b0) begin n_err++; $display("FAIL b2b_done_consecutive[%0d]: got 1 expected 0", ndone); end
            last_done = cyc;
            ndone++;
         end
         prev_done = o_done;
         a = W'($urandom); b = W'($urandom); m = 1'($urandom);
         i_a = a; i_b = b; i_mode = m;
         if (o_done) begin
            if (ndone < 6) q.push_back(model(a, b, m));
            else i_start = 1'b0;
         end
         step();
         cyc++;
      end
      i_start = 1'b0;
      n_vec++;
      if (ndone != 6) begin n_err++; $display("FAIL b2b_timeout: got %0d done pulses expected 6", ndone); end
      step();
   endtask

   task automatic test_random;
      int lat, bc;
      logic [W:0] r, e;
      logic bd, da;
      logic [W-1:0] a, b;
      logic m;
      for (int i = 0; i < 24; i++) begin
         a = W'($urandom); b = W'($urandom); m = 1'($urandom);
         do_txn(a, b, m, lat, bc, r, bd, da);
         e = model(a, b, m);
         n_vec += 2;
         if (r !== e) begin
            n_err++;
            $display("FAIL rand_result[%0d]: a=%0d b=%0d m=%0b got %0d expected %0d", i, a, b, m, r, e);
         end
         if (lat != int'(W)) begin n_err++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, W); end
      end
   endtask

   task automatic test_reset_mid;
      int lat, bc;
      logic [W:0] r;
      logic bd, da;
      do_txn(4'd7, 4'd6, 1'b0, lat, bc, r, bd, da);
      i_a = 4'd3; i_b = 4'd2; i_mode = 1'b0; i_start = 1'b1;
      step();
      i_start = 1'b0;
      step();
      step();
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if ({o_busy, o_done, o_carry, o_sum} !== '0) begin
         n_err++;
         $display("FAIL midreset_async: got %0h expected 0", {o_busy, o_done, o_carry, o_sum});
      end
      @(posedge clk);
      #3 rst_n = 1'b1;
      for (int i = 0; i < int'(W) + 2; i++) begin
         step();
         n_vec++;
         if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_no_done[%0d]: got done=%0b busy=%0b expected 0", i, o_done, o_busy);
         end
      end
      do_txn(4'd3, 4'd2, 1'b0, lat, bc, r, bd, da);
      n_vec++;
      if (r !== 5'b0_0101) begin n_err++; $display("FAIL midreset_restart: got %0d expected 5", r); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub_wrap();
      test_protocol();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/serial_addsub_unit.md
Name: serial_addsub_unit

Overview:
Bit-serial add/subtract engine with a start/done handshake. It accepts one operand pair and mode per transaction and processes one bit per clock, LSB first, through a single full-adder slice and a carry flip-flop. It returns the WIDTH-bit result plus carry-out. It is the sequential, handshaked responder to the operand-driving side of the 4-bit combinational adder/subtractor datapath, and gives bit-identical results to it.

Parameters:
WIDTH, 4, operand and result width in bits; legal range 2..16.

Ports:
i_clk  input  1  rising-edge clock
i_reset_n  input  1  asynchronous active-low reset
i_start  input  1  request; sampled only while idle
i_a  input  WIDTH  operand A, captured on the accepted start edge
i_b  input  WIDTH  operand B, captured on the accepted start edge
i_mode  input  1  0 = A+B, 1 = A-B; captured on the accepted start edge
o_busy  output  1  high while a transaction is in progress
o_done  output  1  single-cycle pulse when o_sum/o_carry are updated
o_sum  output  WIDTH  result, held until the next o_done
o_carry  output  1  carry-out of the MSB; in subtract mode, 1 = no borrow (A >= B unsigned)

Behaviour:
- Reset (asynchronous on i_reset_n low):
  - State returns to IDLE.
  - o_busy = 0, o_done = 0, o_sum = 0, o_carry = 0.
  - Internal shift registers, bit counter and carry flop are cleared.
  - Reset mid-transaction aborts the transaction with no o_done.
- State machine, two states:
  - IDLE: o_busy = 0. If i_start = 1 at a rising edge:
    - Capture A into shift register SA.
    - Capture (B XOR {WIDTH{i_mode}}) into shift register SB.
    - Set carry flop C = i_mode.
    - Set bit counter to 0, go to RUN.
    - o_busy reads 1 from the following cycle.
  - RUN: at each edge:
    - s = SA[0] ^ SB[0] ^ C; C <= majority(SA[0], SB[0], C).
    - Shift s into the result register at MSB, shifting right.
    - Shift SA and SB right; increment the counter.
  - End of RUN: on the edge where counter = WIDTH-1 (the last bit):
    - Load o_sum with the completed result and o_carry with the final carry.
    - Pulse o_done for exactly one cycle; return to IDLE (o_busy = 0 in that cycle).
- Latency:
  - Start accepted at edge 0 → o_done high in the cycle after edge WIDTH.
  - For WIDTH = 4, o_done is high 4 cycles after the start-accept cycle.
  - Throughput: one transaction per WIDTH+1 cycles.
- Arithmetic:
  - Modulo 2^WIDTH, unsigned carry semantics.
  - No overflow flag.
  - Results equal the combinational a + (b ^ mode) + mode.
- Boundary conditions:
  - i_start while o_busy = 1: ignored. Operands are not re-sampled and the in-flight result is unaffected.
  - i_start high in the o_done cycle: the FSM is in IDLE, so the start is accepted (back-to-back operation).
  - i_a, i_b, i_mode changing after acceptance: no effect on the in-flight transaction.
  - i_start held high continuously: transactions run back-to-back, each sampling operands on its own accept edge.
  - o_sum/o_carry change only on the o_done edge and on reset.
  - o_done is never asserted two cycles in a row.

Test Plan:
1. Reset then idle: hold i_reset_n = 0 for 3 cycles with i_start = 1, then release with i_start = 0 → all outputs 0, o_busy stays 0.
2. Add: A=3, B=2, mode=0, single start pulse → after 4 cycles o_done = 1 for one cycle, o_sum = 5, o_carry = 0; o_busy high for the 4 cycles before.
3. Subtract: A=7, B=4, mode=1 → o_sum = 3, o_carry = 1. Then A=2, B=3, mode=1 → o_sum = 15, o_carry = 0 (borrow).
4. Wrap: A=15, B=1, mode=0 → o_sum = 0, o_carry = 1. Then A=0, B=0, mode=1 → o_sum = 0, o_carry = 1.
5. Protocol:
   - Start A=9, B=6, mode=0.
   - Two cycles later pulse i_start with A=1, B=1 and change i_a → ignored; result o_sum = 15, o_carry = 0.
   - Hold i_start high through o_done with A=5, B=5, mode=1 → second o_done exactly 5 cycles after the first, o_sum = 0, o_carry = 1.
6. Reset mid-operation: start A=3, B=2, mode=0; assert i_reset_n = 0 asynchronously two cycles later → o_busy = 0 and o_sum = 0 immediately, no o_done. After release, a new start A=3, B=2, mode=0 gives o_sum = 5.
